// File: rtl/enc_8to3_seq.sv
// Registered 8-to-3 event encoder: captures event pulses into a pending register
// and emits one 3-bit code per valid/ready handshake. `define ENC_ROUND_ROBIN_EN for round-robin selection.
module enc_8to3_seq #(
  parameter int unsigned OVF_STICKY = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic i4,
  input  logic i5,
  input  logic i6,
  input  logic i7,
  input  logic ready,
  output logic valid,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic ovf,
  output logic pend_any
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [7:0]  pend_q, pend_d;
  logic [2:0]  code_q, code_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  in_vec, cand, clr, cur_oh;
  logic [2:0]  sel;
  logic        load, lost;
`ifdef ENC_ROUND_ROBIN_EN
  logic [2:0]  rr_ptr_q, rr_ptr_d;
`endif

  assign in_vec = {i7, i6, i5, i4, i3, i2, i1, i0};
  assign cur_oh = 8'b1 << code_q;
  // In HOLD the code on the outputs is being retired, so its bit is not a candidate
  // even if a fresh event re-set it this cycle.
  assign cand   = (state_q == HOLD) ? (pend_q & ~cur_oh) : pend_q;

`ifdef ENC_ROUND_ROBIN_EN
  always_comb begin
    logic       found;
    logic [2:0] idx;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      idx = rr_ptr_q + 3'(k);
      if (!found && cand[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    sel = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (cand[k]) sel = 3'(k);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    load    = 1'b0;
    clr     = '0;
`ifdef ENC_ROUND_ROBIN_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      IDLE: if (|cand) load = 1'b1;
      HOLD: if (ready) begin
        if (|cand) load = 1'b1;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = HOLD;
      code_d  = sel;
      clr     = 8'b1 << sel;
`ifdef ENC_ROUND_ROBIN_EN
      rr_ptr_d = sel;
`endif
    end
    // Set beats clear: a new event on the index being loaded stays pending.
    pend_d = (pend_q & ~clr) | in_vec;
    lost   = |(in_vec & pend_q & ~clr);
    ovf_d  = (OVF_STICKY != 0) ? (ovf_q | lost) : lost;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
      rr_ptr_q <= 3'd7;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
`ifdef ENC_ROUND_ROBIN_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign valid    = (state_q == HOLD);
  assign s0       = code_q[2];
  assign s1       = code_q[1];
  assign s2       = code_q[0];
  assign ovf      = ovf_q;
  assign pend_any = |pend_q;

endmodule

// File: tb/tb_enc_8to3_seq.sv
// Directed self-checking bench for enc_8to3_seq; a second instance covers OVF_STICKY=1.
module tb_enc_8to3_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ivec = '0;
  logic       ready = 1'b0;
  logic       valid, s0, s1, s2, ovf, pend_any;
  logic       valid_s, s0_s, s1_s, s2_s, ovf_s, pend_any_s;
  logic [2:0] code;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;
  assign code = {s0, s1, s2};

  enc_8to3_seq #(.OVF_STICKY(0)) dut (
    .clk(clk), .rst(rst),
    .i0(ivec[0]), .i1(ivec[1]), .i2(ivec[2]), .i3(ivec[3]),
    .i4(ivec[4]), .i5(ivec[5]), .i6(ivec[6]), .i7(ivec[7]),
    .ready(ready), .valid(valid), .s0(s0), .s1(s1), .s2(s2),
    .ovf(ovf), .pend_any(pend_any)
  );

  enc_8to3_seq #(.OVF_STICKY(1)) dut_sticky (
    .clk(clk), .rst(rst),
    .i0(ivec[0]), .i1(ivec[1]), .i2(ivec[2]), .i3(ivec[3]),
    .i4(ivec[4]), .i5(ivec[5]), .i6(ivec[6]), .i7(ivec[7]),
    .ready(ready), .valid(valid_s), .s0(s0_s), .s1(s1_s), .s2(s2_s),
    .ovf(ovf_s), .pend_any(pend_any_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ivec = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ivec = 8'hFF; ready = 1'b1;
    tick(); tick();
    rst = 1'b0; ivec = '0; ready = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", valid); end
    n_cmp++; if (code !== 3'b000) begin n_err++; $display("FAIL reset_code got=%b exp=000", code); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    n_cmp++; if (pend_any !== 1'b0) begin n_err++; $display("FAIL reset_pend_any got=%b exp=0", pend_any); end
    n_cmp++; if (ovf_s !== 1'b0) begin n_err++; $display("FAIL reset_ovf_sticky got=%b exp=0", ovf_s); end
  endtask

  task automatic test_single();
    ready = 1'b1; ivec = 8'h20;
    tick();
    ivec = '0;
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL single_e1_valid got=%b exp=0", valid); end
    n_cmp++; if (pend_any !== 1'b1) begin n_err++; $display("FAIL single_e1_pend got=%b exp=1", pend_any); end
    tick();
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL single_e2_valid got=%b exp=1", valid); end
    n_cmp++; if (code !== 3'b101) begin n_err++; $display("FAIL single_e2_code got=%b exp=101", code); end
    n_cmp++; if (pend_any !== 1'b0) begin n_err++; $display("FAIL single_e2_pend got=%b exp=0", pend_any); end
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL single_e3_valid got=%b exp=0", valid); end
    n_cmp++; if (code !== 3'b101) begin n_err++; $display("FAIL single_e3_code_kept got=%b exp=101", code); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL single_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_priority();
    logic [2:0] exp_codes [3];
`ifdef ENC_ROUND_ROBIN_EN
    exp_codes = '{3'b000, 3'b011, 3'b111};
`else
    exp_codes = '{3'b111, 3'b011, 3'b000};
`endif
    do_reset();
    ready = 1'b1; ivec = 8'h89;
    tick();
    ivec = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL prio_valid[%0d] got=%b exp=1", k, valid); end
      n_cmp++; if (code !== exp_codes[k]) begin n_err++; $display("FAIL prio_code[%0d] got=%b exp=%b", k, code, exp_codes[k]); end
    end
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL prio_end_valid got=%b exp=0", valid); end
  endtask

  task automatic test_hold();
    ready = 1'b0; ivec = 8'h04;
    tick();
    ivec = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d] got=%b exp=1", k, valid); end
      n_cmp++; if (code !== 3'b010) begin n_err++; $display("FAIL hold_code[%0d] got=%b exp=010", k, code); end
      if (k < 4) tick();
    end
    ready = 1'b1;
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL hold_release got=%b exp=0", valid); end
  endtask

  task automatic test_ovf();
    do_reset();
    ready = 1'b0; ivec = 8'h10;
    tick();
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_e1 got=%b exp=0", ovf); end
    tick();
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_e2_setbeatsclear got=%b exp=0", ovf); end
    n_cmp++; if (code !== 3'b100) begin n_err++; $display("FAIL ovf_e2_code got=%b exp=100", code); end
    n_cmp++; if (pend_any !== 1'b1) begin n_err++; $display("FAIL ovf_e2_pend got=%b exp=1", pend_any); end
    tick();
    ivec = '0;
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_e3_pulse got=%b exp=1", ovf); end
    n_cmp++; if (ovf_s !== 1'b1) begin n_err++; $display("FAIL ovf_e3_sticky got=%b exp=1", ovf_s); end
    tick();
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_e4_pulse_end got=%b exp=0", ovf); end
    n_cmp++; if (ovf_s !== 1'b1) begin n_err++; $display("FAIL ovf_e4_sticky got=%b exp=1", ovf_s); end
    tick(); tick();
    n_cmp++; if (ovf_s !== 1'b1) begin n_err++; $display("FAIL ovf_sticky_hold got=%b exp=1", ovf_s); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_nonsticky_low got=%b exp=0", ovf); end
    do_reset();
    n_cmp++; if (ovf_s !== 1'b0) begin n_err++; $display("FAIL ovf_sticky_reset got=%b exp=0", ovf_s); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_code;
    do_reset();
    ready = 1'b1; ivec = 8'hFF;
    tick();
    ivec = '0;
    for (int k = 0; k < 8; k++) begin
`ifdef ENC_ROUND_ROBIN_EN
      exp_code = 3'(k);
`else
      exp_code = 3'(7 - k);
`endif
      tick();
      n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d] got=%b exp=1", k, valid); end
      n_cmp++; if (code !== exp_code) begin n_err++; $display("FAIL b2b_code[%0d] got=%b exp=%b", k, code, exp_code); end
    end
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL b2b_end_valid got=%b exp=0", valid); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL b2b_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp_code;
`ifdef ENC_ROUND_ROBIN_EN
    exp_code = 3'b101;
`else
    exp_code = 3'b110;
`endif
    do_reset();
    ready = 1'b0; ivec = 8'h60;
    tick();
    ivec = '0;
    tick();
    n_cmp++; if (code !== exp_code) begin n_err++; $display("FAIL mid_code got=%b exp=%b", code, exp_code); end
    ivec = 8'h80;
    tick();
    ivec = '0;
    n_cmp++; if (pend_any !== 1'b1) begin n_err++; $display("FAIL mid_pend got=%b exp=1", pend_any); end
    rst = 1'b1; ready = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got=%b exp=0", valid); end
    n_cmp++; if (code !== 3'b000) begin n_err++; $display("FAIL mid_rst_code got=%b exp=000", code); end
    n_cmp++; if (pend_any !== 1'b0) begin n_err++; $display("FAIL mid_rst_pend got=%b exp=0", pend_any); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL mid_rst_ovf got=%b exp=0", ovf); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL mid_quiet[%0d] got=%b exp=0", k, valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_hold();
    test_ovf();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
